pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Sequences the pipeline registers (PC, IFID, IDEX, EXMEM, MEMWB) of the 5-stage core.
//  Generates per-stage enables and flushes for load-use stalls, taken-branch squashes
//  and data-memory wait states. Also gates MEMWB read-out during the post-reset pipeline fill.
//  Sits beside the datapath: hazard inputs come from the IFID/IDEX/EX stages, outputs drive the stage registers.
// PARAMETERS
//  REG_W        5   register-specifier width
//  FILL_CYCLES  4   cycles after reset before MEMWB output is valid (range 1..15)
//  MEM_TIMEOUT  15  max consecutive MEM_WAIT cycles before ERROR (range 1..255)
//  CNT_W        16  stall counter width
// PORTS
//  Clk          in   1      rising-edge clock
//  Rst_n        in   1      asynchronous active-low reset
//  IDEX_MemRead in   1      instruction in EX is a load
//  IDEX_Rt      in   REG_W  load destination register
//  IFID_Rs      in   REG_W  source reg 1 of instruction in ID
//  IFID_Rt      in   REG_W  source reg 2 of instruction in ID
//  Branch_Taken in   1      branch resolved taken in EX this cycle
//  Mem_Req      in   1      MEM stage is accessing data memory this cycle
//  Mem_Ready    in   1      data memory completes the access this cycle
//  Halt         in   1      halt request (level)
//  PC_En        out  1      PC update enable
//  IFID_En      out  1      IFID stage register enable
//  IDEX_En      out  1      IDEX stage register enable
//  EXMEM_En     out  1      EXMEM stage register enable
//  MEMWB_En     out  1      MEMWB stage register enable
//  IFID_Flush   out  1      load bubble into IFID
//  IDEX_Flush   out  1      load bubble into IDEX
//  MEMWB_Read   out  1      MEMWB output valid (drives Read of MEMWB)
//  Err          out  1      sticky memory-timeout error
//  Stall_Count  out  CNT_W  saturating count of stall cycles
// BEHAVIOUR
//  - Reset (Rst_n=0, async): state=FILL; fill/wait counters, Stall_Count, Err = 0.
//    While in reset, all En, Flush and MEMWB_Read outputs = 0.
//  - State register updates on posedge Clk. En/Flush outputs are combinational from state+inputs (0-cycle latency).
//  - States: FILL, RUN, MEM_WAIT, DRAIN, HALTED, ERROR.
//  - FILL: all En=1, flushes=0, MEMWB_Read=0. Counter increments each cycle.
//    At count==FILL_CYCLES-1 -> RUN. Mem/load/branch hazards are evaluated as in RUN but cannot leave FILL early.
//  - RUN: MEMWB_Read=1. Per-cycle priority, highest first:
//    1 Mem_Req&!Mem_Ready: all En=0 -> MEM_WAIT; wait count=1; Stall_Count++.
//    2 Halt: PC_En=0, IFID_Flush=1, other En=1 -> DRAIN, drain count=0.
//    3 Branch_Taken: all En=1, IFID_Flush=1, IDEX_Flush=1.
//    4 Load-use: IDEX_MemRead && IDEX_Rt!=0 && (IDEX_Rt==IFID_Rs || IDEX_Rt==IFID_Rt).
//      PC_En=0, IFID_En=0, IDEX_Flush=1, EXMEM_En=MEMWB_En=1; Stall_Count++. Stays RUN.
//      The stall lasts one cycle because the inserted bubble clears IDEX_MemRead.
//    5 Otherwise all En=1, flushes=0.
//    Mem_Req&Mem_Ready in the same cycle is a zero-wait access with no stall.
//  - MEM_WAIT: all En=0, MEMWB_Read=1; Stall_Count++ per cycle.
//    Mem_Ready=1 -> all En=1 this cycle -> RUN.
//    Wait count reaching MEM_TIMEOUT without Mem_Ready -> ERROR.
//    Halt is ignored here and re-sampled in RUN.
//  - DRAIN: PC_En=0, IFID_Flush=1, others En=1. Mem waits are honoured as in RUN; the drain counter holds while waiting.
//    After 4 advancing cycles -> HALTED. Branch/load-use are ignored in DRAIN.
//  - HALTED: all En=0, MEMWB_Read=0. Only reset exits.
//  - ERROR: Err=1 (sticky), all En=0, MEMWB_Read=0. Only reset exits.
//  - Stall_Count saturates at all-ones with no wrap.
//  - Reset asserted mid-stall or mid-wait returns to FILL immediately; all outputs are forced 0 asynchronously.
// TESTING
//  - Reset release, no hazards, FILL_CYCLES=4 -> MEMWB_Read=0 for 4 cycles, then 1; all En=1 throughout.
//  - Load x5 in EX, IFID_Rs=5 -> exactly 1 cycle with PC_En=IFID_En=0, IDEX_Flush=1; Stall_Count=1.
//    Same case with IDEX_Rt=0 -> no stall.
//  - Branch_Taken coincident with a load-use match -> IFID_Flush=IDEX_Flush=1, PC_En=1; Stall_Count unchanged.
//  - Mem_Req with Mem_Ready after 3 cycles -> all En=0 for 3 cycles, then 1 in the Mem_Ready cycle; Stall_Count=3.
//    With MEM_TIMEOUT=15 and no ready -> Err=1 after 15 cycles, all En held 0.
//  - Halt in RUN -> PC_En=0 for 5 cycles, then HALTED with all En=0 and MEMWB_Read=0.
//    Rst_n pulse returns the block to FILL and clears Err/Stall_Count.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Pipeline-register sequencer for a 5-stage core. Produces the
//                per-stage enables and bubble flushes for load-use stalls,
//                taken-branch squashes and data-memory wait states. Gates the
//                MEMWB read-out until the pipeline has filled after reset.
//  Ports       : Clk, Rst_n             clock / async active-low reset
//                IDEX_MemRead, IDEX_Rt  load in EX and its destination reg
//                IFID_Rs, IFID_Rt       source regs of the instruction in ID
//                Branch_Taken           branch resolved taken in EX
//                Mem_Req, Mem_Ready     data-memory access / completion
//                Halt                   level halt request
//                PC_En..MEMWB_En        stage register enables
//                IFID_Flush, IDEX_Flush bubble insertion
//                MEMWB_Read             MEMWB output valid
//                Err                    sticky memory-timeout error
//                Stall_Count            saturating stall-cycle counter
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int REG_W       = 5,
    parameter int FILL_CYCLES = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             IDEX_MemRead,
    input  logic [REG_W-1:0] IDEX_Rt,
    input  logic [REG_W-1:0] IFID_Rs,
    input  logic [REG_W-1:0] IFID_Rt,
    input  logic             Branch_Taken,
    input  logic             Mem_Req,
    input  logic             Mem_Ready,
    input  logic             Halt,
    output logic             PC_En,
    output logic             IFID_En,
    output logic             IDEX_En,
    output logic             EXMEM_En,
    output logic             MEMWB_En,
    output logic             IFID_Flush,
    output logic             IDEX_Flush,
    output logic             MEMWB_Read,
    output logic             Err,
    output logic [CNT_W-1:0] Stall_Count
);

    typedef enum logic [2:0] {
        S_FILL     = 3'd0,
        S_RUN      = 3'd1,
        S_MEM_WAIT = 3'd2,
        S_DRAIN    = 3'd3,
        S_HALTED   = 3'd4,
        S_ERROR    = 3'd5
    } state_t;

    // enable vector ordering: {PC, IFID, IDEX, EXMEM, MEMWB}
    localparam logic [4:0] c_EN_ALL   = 5'b11111;
    localparam logic [4:0] c_EN_NONE  = 5'b00000;
    localparam logic [4:0] c_EN_NO_PC = 5'b01111;
    localparam logic [4:0] c_EN_LU    = 5'b00111;
    localparam logic [3:0] c_FILL_LAST = 4'(FILL_CYCLES - 1);

    state_t           r_state;
    logic [3:0]       r_fill_cnt;
    logic [7:0]       r_wait_cnt;   // stall cycles already spent on the current access
    logic [1:0]       r_drain_cnt;
    logic             r_err;
    logic [CNT_W-1:0] r_stall_cnt;

    state_t           w_next;
    logic [3:0]       w_fill_nxt;
    logic [7:0]       w_wait_nxt;
    logic [1:0]       w_drain_nxt;
    logic [4:0]       w_en;
    logic             w_ifid_flush;
    logic             w_idex_flush;
    logic             w_read;
    logic             w_stall_inc;
    logic             w_load_use;
    logic             w_mem_stall;
    logic             w_wait_hit;

    assign w_load_use  = IDEX_MemRead && (IDEX_Rt != '0) &&
                         ((IDEX_Rt == IFID_Rs) || (IDEX_Rt == IFID_Rt));
    assign w_mem_stall = Mem_Req && !Mem_Ready;
    // true when the stall cycle being spent now is the MEM_TIMEOUT-th in a row
    assign w_wait_hit  = (({1'b0, r_wait_cnt} + 9'd1) == 9'(MEM_TIMEOUT));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state     <= S_FILL;
            r_fill_cnt  <= '0;
            r_wait_cnt  <= '0;
            r_drain_cnt <= '0;
            r_err       <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_next;
            r_fill_cnt  <= w_fill_nxt;
            r_wait_cnt  <= w_wait_nxt;
            r_drain_cnt <= w_drain_nxt;
            if (w_next == S_ERROR)
                r_err <= 1'b1;
            if (w_stall_inc && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_next       = r_state;
        w_fill_nxt   = r_fill_cnt;
        w_wait_nxt   = r_wait_cnt;
        w_drain_nxt  = r_drain_cnt;
        w_en         = c_EN_NONE;
        w_ifid_flush = 1'b0;
        w_idex_flush = 1'b0;
        w_read       = 1'b0;
        w_stall_inc  = 1'b0;

        case (r_state)
            S_FILL: begin
                // hazards act on the enables, but the fill sequence always runs to completion
                w_fill_nxt = r_fill_cnt + 4'd1;
                w_wait_nxt = '0;
                if (r_fill_cnt == c_FILL_LAST)
                    w_next = S_RUN;
                if (w_mem_stall) begin
                    w_stall_inc = 1'b1;
                end else if (Branch_Taken) begin
                    w_en         = c_EN_ALL;
                    w_ifid_flush = 1'b1;
                    w_idex_flush = 1'b1;
                end else if (w_load_use) begin
                    w_en         = c_EN_LU;
                    w_idex_flush = 1'b1;
                    w_stall_inc  = 1'b1;
                end else begin
                    w_en = c_EN_ALL;
                end
            end

            S_RUN: begin
                w_read     = 1'b1;
                w_wait_nxt = '0;
                if (w_mem_stall) begin
                    w_stall_inc = 1'b1;
                    w_wait_nxt  = r_wait_cnt + 8'd1;
                    w_next      = w_wait_hit ? S_ERROR : S_MEM_WAIT;
                end else if (Halt) begin
                    w_en         = c_EN_NO_PC;
                    w_ifid_flush = 1'b1;
                    w_drain_nxt  = '0;
                    w_next       = S_DRAIN;
                end else if (Branch_Taken) begin
                    w_en         = c_EN_ALL;
                    w_ifid_flush = 1'b1;
                    w_idex_flush = 1'b1;
                end else if (w_load_use) begin
                    // the bubble clears IDEX_MemRead, so this lasts one cycle
                    w_en         = c_EN_LU;
                    w_idex_flush = 1'b1;
                    w_stall_inc  = 1'b1;
                end else begin
                    w_en = c_EN_ALL;
                end
            end

            S_MEM_WAIT: begin
                w_read = 1'b1;
                if (Mem_Ready) begin
                    w_en       = c_EN_ALL;
                    w_wait_nxt = '0;
                    w_next     = S_RUN;
                end else begin
                    w_stall_inc = 1'b1;
                    w_wait_nxt  = r_wait_cnt + 8'd1;
                    if (w_wait_hit)
                        w_next = S_ERROR;
                end
            end

            S_DRAIN: begin
                // waits freeze the drain count; the access is tracked in place
                w_read = 1'b1;
                if (w_mem_stall) begin
                    w_stall_inc = 1'b1;
                    w_wait_nxt  = r_wait_cnt + 8'd1;
                    if (w_wait_hit)
                        w_next = S_ERROR;
                end else begin
                    w_en         = c_EN_NO_PC;
                    w_ifid_flush = 1'b1;
                    w_wait_nxt   = '0;
                    w_drain_nxt  = r_drain_cnt + 2'd1;
                    if (r_drain_cnt == 2'd3)
                        w_next = S_HALTED;
                end
            end

            S_HALTED: begin
                w_next = S_HALTED;
            end

            S_ERROR: begin
                w_next = S_ERROR;
            end

            default: begin
                w_next = S_ERROR;
            end
        endcase
    end

    // outputs are forced low for as long as reset is held
    assign PC_En       = w_en[4] & Rst_n;
    assign IFID_En     = w_en[3] & Rst_n;
    assign IDEX_En     = w_en[2] & Rst_n;
    assign EXMEM_En    = w_en[1] & Rst_n;
    assign MEMWB_En    = w_en[0] & Rst_n;
    assign IFID_Flush  = w_ifid_flush & Rst_n;
    assign IDEX_Flush  = w_idex_flush & Rst_n;
    assign MEMWB_Read  = w_read & Rst_n;
    assign Err         = r_err;
    assign Stall_Count = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Directed bench for pipe_hazard_ctrl with a cycle-level
//                reference model and hand-computed checkpoints.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int REG_W       = 5;
    localparam int FILL_CYCLES = 4;
    localparam int MEM_TIMEOUT = 15;
    localparam int CNT_W       = 4;
    localparam int SAT         = (1 << CNT_W) - 1;

    localparam int M_FILL = 0, M_RUN = 1, M_WAIT = 2, M_DRAIN = 3, M_HALT = 4, M_ERR = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             idex_memread;
    logic [REG_W-1:0] idex_rt, ifid_rs, ifid_rt;
    logic             branch_taken, mem_req, mem_ready, halt;
    logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic             ifid_flush, idex_flush, memwb_read, err;
    logic [CNT_W-1:0] stall_count;

    int total = 0;
    int bad   = 0;

    pipe_hazard_ctrl #(
        .REG_W(REG_W), .FILL_CYCLES(FILL_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .Clk(clk), .Rst_n(rst_n),
        .IDEX_MemRead(idex_memread), .IDEX_Rt(idex_rt),
        .IFID_Rs(ifid_rs), .IFID_Rt(ifid_rt),
        .Branch_Taken(branch_taken), .Mem_Req(mem_req), .Mem_Ready(mem_ready), .Halt(halt),
        .PC_En(pc_en), .IFID_En(ifid_en), .IDEX_En(idex_en), .EXMEM_En(exmem_en), .MEMWB_En(memwb_en),
        .IFID_Flush(ifid_flush), .IDEX_Flush(idex_flush), .MEMWB_Read(memwb_read),
        .Err(err), .Stall_Count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] dut_en();
        return {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
    endfunction

    // ------------------------------------------------------------------
    // Reference model: per-cycle outputs derived from the hazard rules.
    // Output vector = {PC,IFID,IDEX,EXMEM,MEMWB en, IFID flush, IDEX flush, read}
    // ------------------------------------------------------------------
    int m_mode = M_FILL;
    int m_filled = 0;
    int m_waited = 0;
    int m_drained = 0;
    int m_err = 0;
    int m_stalls = 0;

    always @(negedge clk) begin
        logic [4:0] en;
        logic       ifl, idfl, rd;
        int         inc, nxt;
        logic       mstall, lu;
        if (!rst_n) begin
            chk("reset_outputs", int'({dut_en(), ifid_flush, idex_flush, memwb_read}), 0);
            chk("reset_err", int'(err), 0);
            chk("reset_stalls", int'(stall_count), 0);
            m_mode = M_FILL; m_filled = 0; m_waited = 0; m_drained = 0; m_err = 0; m_stalls = 0;
        end else begin
            mstall = mem_req && !mem_ready;
            lu     = idex_memread && (idex_rt != 0) && (idex_rt == ifid_rs || idex_rt == ifid_rt);
            en = 5'b11111; ifl = 0; idfl = 0; rd = 0; inc = 0; nxt = m_mode;
            case (m_mode)
                M_FILL, M_RUN: begin
                    rd = (m_mode == M_RUN);
                    if (mstall) begin
                        en = 0; inc = 1;
                        if (m_mode == M_RUN) begin
                            m_waited = 1;
                            nxt = (MEM_TIMEOUT <= 1) ? M_ERR : M_WAIT;
                        end
                    end else if (m_mode == M_RUN && halt) begin
                        en = 5'b01111; ifl = 1; m_drained = 0; nxt = M_DRAIN;
                    end else if (branch_taken) begin
                        ifl = 1; idfl = 1;
                    end else if (lu) begin
                        en = 5'b00111; idfl = 1; inc = 1;
                    end
                    if (m_mode == M_FILL) begin
                        m_filled++;
                        if (m_filled == FILL_CYCLES) nxt = M_RUN;
                    end
                end
                M_WAIT: begin
                    rd = 1;
                    if (mem_ready) begin
                        m_waited = 0; nxt = M_RUN;
                    end else begin
                        en = 0; inc = 1; m_waited++;
                        if (m_waited >= MEM_TIMEOUT) nxt = M_ERR;
                    end
                end
                M_DRAIN: begin
                    rd = 1;
                    if (mstall) begin
                        en = 0; inc = 1; m_waited++;
                        if (m_waited >= MEM_TIMEOUT) nxt = M_ERR;
                    end else begin
                        en = 5'b01111; ifl = 1; m_waited = 0; m_drained++;
                        if (m_drained == 4) nxt = M_HALT;
                    end
                end
                default: begin
                    en = 0;
                end
            endcase
            chk("model_outputs", int'({dut_en(), ifid_flush, idex_flush, memwb_read}),
                int'({en, ifl, idfl, rd}));
            chk("model_err", int'(err), m_err);
            chk("model_stalls", int'(stall_count), m_stalls);
            m_stalls = (m_stalls + inc > SAT) ? SAT : m_stalls + inc;
            if (nxt == M_ERR) m_err = 1;
            m_mode = nxt;
        end
    end

    task automatic clear_inputs();
        idex_memread = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
        branch_taken = 0; mem_req = 0; mem_ready = 0; halt = 0;
    endtask

    // ------------------------------------------------------------------
    // Directed stimulus with hand-computed checkpoints
    // ------------------------------------------------------------------
    initial begin
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) tick();
        chk("rst_read", int'(memwb_read), 0);
        chk("rst_stall_count", int'(stall_count), 0);
        rst_n = 1'b1;

        // pipeline fill: 4 cycles without read-out, enables high throughout
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("fill_read", int'(memwb_read), 0);
            chk("fill_en", int'(dut_en()), 31);
        end
        @(negedge clk); #1;
        chk("run_read", int'(memwb_read), 1);

        // load x5 in EX, ID reads x5: one-cycle stall
        tick();
        idex_memread = 1; idex_rt = 5; ifid_rs = 5; ifid_rt = 7;
        @(negedge clk); #1;
        chk("lu_en", int'(dut_en()), 5'b00111);
        chk("lu_idex_flush", int'(idex_flush), 1);
        tick();
        clear_inputs();
        @(negedge clk); #1;
        chk("lu_after_pc_en", int'(pc_en), 1);
        chk("lu_stall_count", int'(stall_count), 1);

        // load to x0 never stalls
        tick();
        idex_memread = 1; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
        @(negedge clk); #1;
        chk("x0_en", int'(dut_en()), 31);
        chk("x0_idex_flush", int'(idex_flush), 0);

        // taken branch outranks a load-use match on ifid_rt
        tick();
        idex_memread = 1; idex_rt = 9; ifid_rs = 3; ifid_rt = 9; branch_taken = 1;
        @(negedge clk); #1;
        chk("br_flushes", int'({ifid_flush, idex_flush}), 3);
        chk("br_pc_en", int'(pc_en), 1);
        tick();
        clear_inputs();
        @(negedge clk); #1;
        chk("br_stall_count", int'(stall_count), 1);

        // memory access ready after 3 stall cycles
        tick();
        mem_req = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("mem_wait_en", int'(dut_en()), 0);
            tick();
        end
        mem_ready = 1;
        @(negedge clk); #1;
        chk("mem_ready_en", int'(dut_en()), 31);
        tick();
        clear_inputs();
        @(negedge clk); #1;
        chk("mem_stall_count", int'(stall_count), 4);

        // halt: PC held for 5 cycles, then everything stops
        tick();
        halt = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("drain_pc_en", int'(pc_en), 0);
            chk("drain_ifid_flush", int'(ifid_flush), 1);
            tick();
        end
        @(negedge clk); #1;
        chk("halted_en", int'(dut_en()), 0);
        chk("halted_read", int'(memwb_read), 0);

        // reset pulse out of HALTED
        tick();
        rst_n = 0; halt = 0;
        #1;
        chk("rst_pulse_stalls", int'(stall_count), 0);
        tick();
        rst_n = 1;
        repeat (4) tick();
        idex_memread = 1; idex_rt = 4; ifid_rs = 4;
        tick();
        clear_inputs();

        // memory timeout: 15 stall cycles then sticky error; counter saturates at 15
        mem_req = 1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk); #1;
            chk("to_en", int'(dut_en()), 0);
            chk("to_err_low", int'(err), 0);
            tick();
        end
        @(negedge clk); #1;
        chk("to_err", int'(err), 1);
        chk("to_stall_sat", int'(stall_count), 15);
        chk("to_read", int'(memwb_read), 0);
        tick();
        mem_ready = 1;
        @(negedge clk); #1;
        chk("to_err_sticky", int'(err), 1);
        chk("to_en_held", int'(dut_en()), 0);

        // reset clears Err and Stall_Count asynchronously
        tick();
        rst_n = 0; clear_inputs();
        #1;
        chk("rst_err_clear", int'(err), 0);
        chk("rst_stall_clear", int'(stall_count), 0);
        tick();
        rst_n = 1;
        repeat (4) tick();

        // reset asserted mid-wait forces outputs low immediately
        mem_req = 1;
        @(negedge clk); #1;
        tick();
        @(negedge clk); #1;
        chk("midwait_read", int'(memwb_read), 1);
        tick();
        rst_n = 0;
        #1;
        chk("midwait_rst_read", int'(memwb_read), 0);
        chk("midwait_rst_stalls", int'(stall_count), 0);
        mem_req = 0;
        tick();
        rst_n = 1;
        repeat (6) tick();
        chk("final_read", int'(memwb_read), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
